blt_update_sched: RTL and testbench

- Schedules branch-resolution updates into the branch lookup table's single write port.
- Two requesters share the port: req0 = branch unit (conditional outcome), req1 = jump unit (target learn).
- A round-robin arbiter feeds a small FIFO, which drains one update per cycle into the table's write/write_key/write_val/hit inputs.
- Also sequences a table flush: discard queue, pulse the table reset, acknowledge.

---
 rtl/blt_update_sched.sv | 158 +++++++++++++++
 tb/tb_blt_update_sched.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blt_update_sched.sv
// Branch lookup table update scheduler: round-robin arbiter, small FIFO,
// single-port drain and table flush sequencing.
module blt_update_sched #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_key,
  input  logic [ADDR_WIDTH-1:0] req0_val,
  input  logic                  req0_hit,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_key,
  input  logic [ADDR_WIDTH-1:0] req1_val,
  input  logic                  req1_hit,
  input  logic                  inhibit,
  input  logic                  flush_req,
  output logic                  flush_ack,
  output logic                  blt_write,
  output logic [ADDR_WIDTH-1:0] blt_write_key,
  output logic [ADDR_WIDTH-1:0] blt_write_val,
  output logic                  blt_hit,
  output logic                  blt_reset,
  output logic [DEPTH_LOG2:0]   count
);

  typedef enum logic [1:0] {
    S_RUN,
    S_FLUSH,
    S_ACK
  } state_e;

  localparam logic [DEPTH_LOG2:0]   FULL    = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] key_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] val_mem [DEPTH];
  logic [DEPTH-1:0]      hit_mem;

  logic [DEPTH_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  rr_q;

  logic                  wr_q, hit_q, rst_q, ack_q;
  logic [ADDR_WIDTH-1:0] key_q, val_q;

  logic                  run, open, drain_ok;
  logic                  gnt0, gnt1, acc0, acc1, acc;
  logic                  pop, bypass, push;
  logic [ADDR_WIDTH-1:0] in_key, in_val;
  logic                  in_hit;

  assign run      = (state_q == S_RUN);
  assign open     = run & ~flush_req & (count_q != FULL);
  assign drain_ok = run & ~flush_req & ~inhibit;

  assign gnt0 = req0_valid & (~req1_valid | ~rr_q);
  assign gnt1 = req1_valid & (~req0_valid | rr_q);

  assign req0_ready = open & gnt0;
  assign req1_ready = open & gnt1;

  assign acc0 = req0_valid & req0_ready;
  assign acc1 = req1_valid & req1_ready;
  assign acc  = acc0 | acc1;

  assign in_key = acc1 ? req1_key : req0_key;
  assign in_val = acc1 ? req1_val : req0_val;
  assign in_hit = acc1 ? req1_hit : req0_hit;

  // An empty FIFO forwards the accepted entry straight to the table port.
  assign pop    = drain_ok & (count_q != '0);
  assign bypass = drain_ok & (count_q == '0) & acc;
  assign push   = acc & ~bypass;

  always_comb begin
    count_d = count_q;
    if (push & ~pop) begin
      count_d = count_q + CNT_ONE;
    end else if (pop & ~push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush_req) state_d = S_FLUSH;
      S_FLUSH: state_d = S_ACK;
      S_ACK:   state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      key_mem[wr_ptr_q] <= in_key;
      val_mem[wr_ptr_q] <= in_val;
      hit_mem[wr_ptr_q] <= in_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      rr_q     <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      wr_q     <= 1'b0;
      key_q    <= '0;
      val_q    <= '0;
      hit_q    <= 1'b0;
      rst_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) rr_q <= ~rr_q;
      if (state_q == S_FLUSH) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        count_q <= count_d;
      end
      wr_q <= pop | bypass;
      if (pop) begin
        key_q <= key_mem[rd_ptr_q];
        val_q <= val_mem[rd_ptr_q];
        hit_q <= hit_mem[rd_ptr_q];
      end else if (bypass) begin
        key_q <= in_key;
        val_q <= in_val;
        hit_q <= in_hit;
      end
      rst_q <= (state_q == S_FLUSH);
      ack_q <= (state_q == S_ACK);
    end
  end

  assign blt_write     = wr_q;
  assign blt_write_key = key_q;
  assign blt_write_val = val_q;
  assign blt_hit       = hit_q;
  assign blt_reset     = rst_q;
  assign flush_ack     = ack_q;
  assign count         = count_q;

endmodule

// File: tb/tb_blt_update_sched.sv
// Scoreboard bench for blt_update_sched against a queue-based
// reference model of the arbiter, FIFO and flush sequence.
module tb_blt_update_sched;

  localparam int AW = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0;
  logic req0_ready, req1_ready;
  logic [AW-1:0] req0_key = 0, req0_val = 0;
  logic [AW-1:0] req1_key = 0, req1_val = 0;
  logic req0_hit = 0, req1_hit = 0;
  logic inhibit = 0, flush_req = 0;
  logic flush_ack, blt_write, blt_hit, blt_reset;
  logic [AW-1:0] blt_write_key, blt_write_val;
  logic [2:0] count;

  blt_update_sched #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_key(req0_key), .req0_val(req0_val), .req0_hit(req0_hit),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_key(req1_key), .req1_val(req1_val), .req1_hit(req1_hit),
    .inhibit(inhibit), .flush_req(flush_req), .flush_ack(flush_ack),
    .blt_write(blt_write), .blt_write_key(blt_write_key),
    .blt_write_val(blt_write_val), .blt_hit(blt_hit),
    .blt_reset(blt_reset), .count(count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] key;
    logic [AW-1:0] val;
    logic          hit;
    int            cyc;
  } ent_t;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: the FIFO is a queue, the table port a queue of
  // expected writes tagged with the cycle they must appear in.
  typedef enum {M_RUN, M_FLUSH, M_ACK} mst_e;
  mst_e m_st = M_RUN;
  bit   m_rr = 0;
  ent_t mq[$];
  ent_t expq[$];
  bit   e_rst = 0, e_ack = 0;
  bit   last0 = 0, last1 = 0;

  function automatic bit g0();
    return req0_valid && (!req1_valid || !m_rr);
  endfunction
  function automatic bit g1();
    return req1_valid && (!req0_valid || m_rr);
  endfunction
  function automatic bit room();
    return m_st == M_RUN && !flush_req && mq.size() < DEPTH;
  endfunction

  task automatic model_update();
    ent_t e;
    bit acc, byp;
    last0 = 0;
    last1 = 0;
    if (reset) begin
      mq.delete();
      expq.delete();
      m_st = M_RUN;
      m_rr = 0;
      e_rst = 0;
      e_ack = 0;
      return;
    end
    e_rst = (m_st == M_FLUSH);
    e_ack = (m_st == M_ACK);
    case (m_st)
      M_FLUSH: begin
        mq.delete();
        m_st = M_ACK;
      end
      M_ACK: m_st = M_RUN;
      default: begin
        if (flush_req) begin
          m_st = M_FLUSH;
        end else begin
          acc = room() && (g0() || g1());
          last1 = acc && g1();
          last0 = acc && !g1();
          e.key = last1 ? req1_key : req0_key;
          e.val = last1 ? req1_val : req0_val;
          e.hit = last1 ? req1_hit : req0_hit;
          e.cyc = cyc + 1;
          if (acc) m_rr = !m_rr;
          byp = 0;
          if (!inhibit) begin
            if (mq.size() > 0) begin
              ent_t h;
              h = mq.pop_front();
              h.cyc = cyc + 1;
              expq.push_back(h);
            end else if (acc) begin
              expq.push_back(e);
              byp = 1;
            end
          end
          if (acc && !byp) mq.push_back(e);
        end
      end
    endcase
  endtask

  task automatic step();
    #1;
    if (!reset) begin
      chk("req0_ready", 32'(req0_ready), 32'(room() && g0()));
      chk("req1_ready", 32'(req1_ready), 32'(room() && g1()));
    end
    model_update();
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("blt_reset", 32'(blt_reset), 32'(e_rst));
    chk("flush_ack", 32'(flush_ack), 32'(e_ack));
    if (blt_write && blt_reset) chk("write_and_reset", 1, 0);
  endtask

  // Monitor: every table write must match the oldest expected write.
  initial begin
    ent_t x;
    forever begin
      @(negedge clk);
      if (blt_write) begin
        if (expq.size() == 0) begin
          chk("unexpected_write", 32'(blt_write_key), 32'hFFFF_FFFF);
        end else begin
          x = expq.pop_front();
          chk("write_key", 32'(blt_write_key), 32'(x.key));
          chk("write_val", 32'(blt_write_val), 32'(x.val));
          chk("write_hit", 32'(blt_hit), 32'(x.hit));
          chk("write_cycle", 32'(cyc), 32'(x.cyc));
        end
      end
    end
  end

  task automatic idle();
    req0_valid = 0;
    req1_valid = 0;
    inhibit = 0;
    flush_req = 0;
  endtask

  initial begin
    int hold;
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    step();
    step();
    chk("rst_write", 32'(blt_write), 0);
    chk("rst_count", 32'(count), 0);
    reset = 0;
    step();

    // Single update with bypass latency of one cycle.
    req0_valid = 1;
    req0_key = 16'h0040;
    req0_val = 16'h0100;
    req0_hit = 1;
    #1;
    chk("single_ready", 32'(req0_ready), 1);
    step();
    req0_valid = 0;
    chk("single_write", 32'(blt_write), 1);
    chk("single_key", 32'(blt_write_key), 32'h0040);
    chk("single_cnt", 32'(count), 0);
    step();
    step();

    // Contention: both valid, grants alternate.
    req0_key = 16'h0010;
    req1_key = 16'h0020;
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 8; i++) begin
      req0_val = 16'h1000 + 16'(i);
      req1_val = 16'h2000 + 16'(i);
      req1_hit = 16'(i) % 2 == 0;
      step();
      if (last0) req0_key++;
      if (last1) req1_key++;
    end
    idle();
    repeat (6) step();

    // Fill under inhibit, then release.
    inhibit = 1;
    req0_valid = 1;
    req0_key = 16'h0300;
    for (int i = 0; i < 5; i++) begin
      step();
      if (last0) req0_key++;
    end
    chk("full_cnt", 32'(count), 4);
    #1;
    chk("full_ready", 32'(req0_ready), 0);
    inhibit = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last0) req0_key++;
      if (req0_key == 16'h0305) req0_valid = 0;
    end
    idle();
    repeat (4) step();

    // Push/pop at count 2 keeps occupancy.
    inhibit = 1;
    req0_valid = 1;
    req0_key = 16'h0400;
    for (int i = 0; i < 2; i++) begin
      step();
      if (last0) req0_key++;
    end
    inhibit = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last0) req0_key++;
      chk("pp_cnt", 32'(count), 2);
    end
    idle();
    repeat (5) step();

    // Flush with three queued entries.
    inhibit = 1;
    req1_valid = 1;
    req1_key = 16'h0500;
    for (int i = 0; i < 3; i++) begin
      step();
      if (last1) req1_key++;
    end
    req1_valid = 0;
    flush_req = 1;
    repeat (3) step();
    flush_req = 0;
    inhibit = 0;
    repeat (3) step();
    chk("flush_cnt", 32'(count), 0);

    // Reset while in FLUSH.
    flush_req = 1;
    for (int i = 0; i < 4 && m_st != M_FLUSH; i++) step();
    flush_req = 0;
    reset = 1;
    step();
    reset = 0;
    chk("mid_rst_write", 32'(blt_write), 0);
    chk("mid_rst_blt_reset", 32'(blt_reset), 0);
    step();
    chk("mid_rst_ack", 32'(flush_ack), 0);

    // Randomized traffic.
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      req0_valid = ($urandom_range(0, 9) < 6);
      req1_valid = ($urandom_range(0, 9) < 5);
      req0_key = 16'($urandom);
      req0_val = 16'($urandom);
      req0_hit = 1'($urandom);
      req1_key = 16'($urandom);
      req1_val = 16'($urandom);
      req1_hit = 1'($urandom);
      inhibit = ($urandom_range(0, 9) < 3);
      if (hold > 0) begin
        hold--;
      end else if ($urandom_range(0, 99) < 3) begin
        hold = $urandom_range(1, 5);
      end
      flush_req = (hold > 0);
      step();
    end
    idle();
    repeat (8) step();
    chk("drained", 32'(expq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
